// File: rtl/cwm_phase_gen.sv
// cwm_phase_gen: wrapped phase accumulator feeding the TX CWM CORDIC stage.
// It emits one signed Q2.13 angle per sample strobe. Every angle it emits lies in
// [-PI_Q, PI_Q). It supports a burst length, abort and a config handshake.
//
// Optional build macro: CWM_SWEEP_EN adds cfg_step_i. This input makes a linear
// chirp: fcw is stepped after every emitted theta and saturated.
//
// Ports
//   clk            clock
//   rst            asynchronous reset, active-low
//   cfg_valid_i    config offer
//   cfg_ready_o    config accept, high only in IDLE
//   cfg_fcw_i      signed Q2.13 phase step per sample
//   cfg_phase0_i   signed Q2.13 start phase, folded once into range on capture
//   cfg_len_i      samples per burst, 0 = continuous
//   cfg_step_i     (CWM_SWEEP_EN only) signed Q2.13 fcw increment per sample
//   start_i        begin burst (IDLE only)
//   abort_i        return to IDLE next cycle, no done
//   sample_en_i    sample strobe, one theta per strobe while running
//   theta_o        signed Q2.13 angle
//   theta_valid_o  1-cycle pulse, theta_o is new
//   wrap_o         accumulator wrapped while producing this theta's successor
//   busy_o         state != IDLE
//   done_o         1-cycle pulse at burst end
//
// state | meaning
// IDLE  | accepts config and start, outputs quiet
// RUN   | one theta per strobe, leaves after the len-th theta
// DONE  | done_o is high for this one cycle, then IDLE
module cwm_phase_gen #(
   parameter int LEN_W    = 16,
   parameter int PI_Q     = 25736,
   parameter int TWO_PI_Q = 51472
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid_i,
   output logic             cfg_ready_o,
   input  logic [15:0]      cfg_fcw_i,
   input  logic [15:0]      cfg_phase0_i,
   input  logic [LEN_W-1:0] cfg_len_i,
`ifdef CWM_SWEEP_EN
   input  logic [15:0]      cfg_step_i,
`endif
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             sample_en_i,
   output logic [15:0]      theta_o,
   output logic             theta_valid_o,
   output logic             wrap_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam logic signed [16:0] PI_S      = 17'(PI_Q);
   localparam logic signed [16:0] NEG_PI_S  = 17'(-PI_Q);
   localparam logic [15:0]        TWO_PI_LO = 16'(TWO_PI_Q);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q;
   logic [15:0]      acc_q;
   logic [15:0]      fcw_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt_q;
   logic [15:0]      theta_q;
   logic             theta_valid_q;
   logic             wrap_q;
   logic             done_q;

   logic signed [16:0] sum_s;
   logic [15:0]        acc_d;
   logic               wrap_d;
   logic signed [16:0] ph_s;
   logic [15:0]        ph_d;
   logic               term;

   // Folding adds or subtracts 2*pi once. The folded value always fits in 16 bits,
   // so the fold can be done on the low 16 bits directly.
   always_comb begin
      sum_s  = {acc_q[15], acc_q} + {fcw_q[15], fcw_q};
      acc_d  = sum_s[15:0];
      wrap_d = 1'b0;
      if (sum_s >= PI_S) begin
         acc_d  = sum_s[15:0] - TWO_PI_LO;
         wrap_d = 1'b1;
      end else if (sum_s < NEG_PI_S) begin
         acc_d  = sum_s[15:0] + TWO_PI_LO;
         wrap_d = 1'b1;
      end
   end

   always_comb begin
      ph_s = {cfg_phase0_i[15], cfg_phase0_i};
      ph_d = cfg_phase0_i;
      if (ph_s >= PI_S)
         ph_d = cfg_phase0_i - TWO_PI_LO;
      else if (ph_s < NEG_PI_S)
         ph_d = cfg_phase0_i + TWO_PI_LO;
   end

`ifdef CWM_SWEEP_EN
   localparam logic signed [16:0] FCW_MAX_S = 17'(PI_Q - 1);
   localparam logic signed [16:0] FCW_MIN_S = 17'(-(PI_Q - 1));

   logic [15:0]        step_q;
   logic signed [16:0] fsum_s;
   logic [15:0]        fcw_d;

   always_comb begin
      fsum_s = {fcw_q[15], fcw_q} + {step_q[15], step_q};
      fcw_d  = fsum_s[15:0];
      if (fsum_s > FCW_MAX_S)
         fcw_d = FCW_MAX_S[15:0];
      else if (fsum_s < FCW_MIN_S)
         fcw_d = FCW_MIN_S[15:0];
   end
`else
   logic [15:0] fcw_d;
   assign fcw_d = fcw_q;
`endif

   // The len-th theta has been emitted. A length of 0 never terminates.
   assign term = (len_q != '0) && (cnt_q == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         acc_q         <= '0;
         fcw_q         <= '0;
         len_q         <= '0;
         cnt_q         <= '0;
         theta_q       <= '0;
         theta_valid_q <= 1'b0;
         wrap_q        <= 1'b0;
         done_q        <= 1'b0;
`ifdef CWM_SWEEP_EN
         step_q        <= '0;
`endif
      end else begin
         theta_valid_q <= 1'b0;
         wrap_q        <= 1'b0;
         done_q        <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cfg_valid_i) begin
                  fcw_q <= cfg_fcw_i;
                  len_q <= cfg_len_i;
                  acc_q <= ph_d;
`ifdef CWM_SWEEP_EN
                  step_q <= cfg_step_i;
`endif
               end
               // A config offered in the same cycle as start is the one the burst uses.
               if (start_i) begin
                  state_q <= S_RUN;
                  cnt_q   <= cfg_valid_i ? cfg_len_i : len_q;
               end
            end
            S_RUN: begin
               if (abort_i) begin
                  state_q <= S_IDLE;
               end else if (term) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else if (sample_en_i) begin
                  theta_q       <= acc_q;
                  theta_valid_q <= 1'b1;
                  wrap_q        <= wrap_d;
                  acc_q         <= acc_d;
                  fcw_q         <= fcw_d;
                  if (len_q != '0)
                     cnt_q <= cnt_q - 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cfg_ready_o   = (state_q == S_IDLE);
   assign busy_o        = (state_q != S_IDLE);
   assign theta_o       = theta_q;
   assign theta_valid_o = theta_valid_q;
   assign wrap_o        = wrap_q;
   assign done_o        = done_q;

endmodule

// File: tb/tb_cwm_phase_gen.sv
// Directed bench for cwm_phase_gen: burst table plus hand sequences for
// resume, abort, continuous mode, handshake and asynchronous reset.
module tb_cwm_phase_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [15:0] cfg_fcw = '0;
   logic [15:0] cfg_phase0 = '0;
   logic [15:0] cfg_len = '0;
`ifdef CWM_SWEEP_EN
   logic [15:0] cfg_step = '0;
`endif
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        sample_en = 1'b0;
   logic [15:0] theta;
   logic        theta_valid;
   logic        wrap;
   logic        busy;
   logic        done;

   int checks = 0;
   int failures = 0;

   cwm_phase_gen #(.LEN_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_valid_i  (cfg_valid),
      .cfg_ready_o  (cfg_ready),
      .cfg_fcw_i    (cfg_fcw),
      .cfg_phase0_i (cfg_phase0),
      .cfg_len_i    (cfg_len),
`ifdef CWM_SWEEP_EN
      .cfg_step_i   (cfg_step),
`endif
      .start_i      (start),
      .abort_i      (abort),
      .sample_en_i  (sample_en),
      .theta_o      (theta),
      .theta_valid_o(theta_valid),
      .wrap_o       (wrap),
      .busy_o       (busy),
      .done_o       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference wrapped add. w reports whether this add needed folding.
   function automatic logic [15:0] wadd(input logic [15:0] a, input logic [15:0] f,
                                        output logic w);
      int s;
      s = int'($signed(a)) + int'($signed(f));
      w = 1'b0;
      if (s >= 25736) begin
         s -= 51472;
         w = 1'b1;
      end else if (s < -25736) begin
         s += 51472;
         w = 1'b1;
      end
      return 16'(s);
   endfunction

   typedef struct {
      logic [15:0] phase0;
      logic [15:0] fcw;
      logic [15:0] len;
      int          n;
      logic [15:0] th[4];
      logic        wr[4];
   } vec_t;

   localparam int NV = 7;
   vec_t vecs[NV];

   logic [15:0] exp_th, nxt_th, last_th;
   logic        exp_w;
   int          nvalid;
   logic        saw_done;

   initial begin
      // wrap_o goes with the theta whose successor needed folding.
      vecs[0] = '{phase0:16'h0000, fcw:16'h0800, len:16'd4, n:4,
                  th:'{16'h0000, 16'h0800, 16'h1000, 16'h1800}, wr:'{1'b0, 1'b0, 1'b0, 1'b0}};
      vecs[1] = '{phase0:16'h6000, fcw:16'h0800, len:16'd3, n:3,
                  th:'{16'h6000, 16'h9EF0, 16'hA6F0, 16'h0000}, wr:'{1'b1, 1'b0, 1'b0, 1'b0}};
      vecs[2] = '{phase0:16'h9B78, fcw:16'hFF00, len:16'd2, n:2,
                  th:'{16'h9B78, 16'h6388, 16'h0000, 16'h0000}, wr:'{1'b1, 1'b0, 1'b0, 1'b0}};
      vecs[3] = '{phase0:16'h7000, fcw:16'h0000, len:16'd2, n:2,
                  th:'{16'hA6F0, 16'hA6F0, 16'h0000, 16'h0000}, wr:'{1'b0, 1'b0, 1'b0, 1'b0}};
      vecs[4] = '{phase0:16'h6488, fcw:16'h0001, len:16'd2, n:2,
                  th:'{16'h9B78, 16'h9B79, 16'h0000, 16'h0000}, wr:'{1'b0, 1'b0, 1'b0, 1'b0}};
      vecs[5] = '{phase0:16'h8000, fcw:16'h0100, len:16'd1, n:1,
                  th:'{16'h4910, 16'h0000, 16'h0000, 16'h0000}, wr:'{1'b0, 1'b0, 1'b0, 1'b0}};
      vecs[6] = '{phase0:16'h6400, fcw:16'h0087, len:16'd3, n:3,
                  th:'{16'h6400, 16'h6487, 16'h9BFE, 16'h0000}, wr:'{1'b0, 1'b1, 1'b0, 1'b0}};

      // Reset state, checked while reset is held.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_theta", theta, 16'h0);
      chk("rst_valid", theta_valid, 1'b0);
      chk("rst_wrap", wrap, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_cfg_ready", cfg_ready, 1'b1);
      rst = 1'b1;
      step();

      // Burst table.
      for (int v = 0; v < NV; v++) begin
         cfg_valid  = 1'b1;
         cfg_fcw    = vecs[v].fcw;
         cfg_phase0 = vecs[v].phase0;
         cfg_len    = vecs[v].len;
         start      = 1'b1;
         step();
         cfg_valid = 1'b0;
         start     = 1'b0;
         chk($sformatf("v%0d_busy", v), busy, 1'b1);
         chk($sformatf("v%0d_cfg_ready_run", v), cfg_ready, 1'b0);
         for (int k = 0; k < vecs[v].n; k++) begin
            sample_en = 1'b1;
            step();
            chk($sformatf("v%0d_s%0d_valid", v, k), theta_valid, 1'b1);
            chk($sformatf("v%0d_s%0d_theta", v, k), theta, vecs[v].th[k]);
            chk($sformatf("v%0d_s%0d_wrap", v, k), wrap, vecs[v].wr[k]);
            chk($sformatf("v%0d_s%0d_done", v, k), done, 1'b0);
         end
         // The strobe stays high: it must not produce an extra theta after the last one.
         step();
         chk($sformatf("v%0d_end_valid", v), theta_valid, 1'b0);
         chk($sformatf("v%0d_end_done", v), done, 1'b1);
         chk($sformatf("v%0d_end_busy", v), busy, 1'b1);
         sample_en = 1'b0;
         step();
         chk($sformatf("v%0d_idle_done", v), done, 1'b0);
         chk($sformatf("v%0d_idle_busy", v), busy, 1'b0);
      end

      // Start again without new config: the phase continues from 0x9C85.
      start = 1'b1;
      step();
      start     = 1'b0;
      sample_en = 1'b1;
      step();
      chk("resume_valid", theta_valid, 1'b1);
      chk("resume_theta", theta, 16'h9C85);
      abort = 1'b1;
      step();
      chk("resume_abort_valid", theta_valid, 1'b0);
      chk("resume_abort_busy", busy, 1'b0);
      chk("resume_abort_done", done, 1'b0);
      chk("resume_abort_theta", theta, 16'h9C85);
      abort = 1'b0;
      // A strobe while in IDLE is ignored.
      step();
      chk("idle_strobe_valid", theta_valid, 1'b0);
      sample_en = 1'b0;

      // Continuous run. Config and start come in the same cycle, and the new phase0 leads.
      cfg_valid  = 1'b1;
      cfg_fcw    = 16'h0400;
      cfg_phase0 = 16'h0000;
      cfg_len    = 16'd0;
      start      = 1'b1;
      step();
      cfg_valid = 1'b0;
      start     = 1'b0;
      exp_th    = 16'h0000;
      nvalid    = 0;
      saw_done  = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (i == 50) begin
            cfg_valid  = 1'b1;
            cfg_fcw    = 16'h0300;
            cfg_phase0 = 16'h1234;
            chk("run_cfg_ready", cfg_ready, 1'b0);
         end
         sample_en = 1'b1;
         step();
         cfg_valid = 1'b0;
         nxt_th = wadd(exp_th, 16'h0400, exp_w);
         if (theta_valid) nvalid++;
         if (done) saw_done = 1'b1;
         chk($sformatf("cont_s%0d_theta", i), theta, exp_th);
         chk($sformatf("cont_s%0d_wrap", i), wrap, exp_w);
         last_th = exp_th;
         exp_th  = nxt_th;
      end
      abort = 1'b1;
      step();
      chk("cont_abort_valid", theta_valid, 1'b0);
      chk("cont_abort_theta", theta, last_th);
      chk("cont_abort_busy", busy, 1'b0);
      chk("cont_abort_done", done, 1'b0);
      chk("cont_nvalid", nvalid, 100);
      chk("cont_saw_done", saw_done, 1'b0);
      abort     = 1'b0;
      sample_en = 1'b0;

      // Asynchronous reset while running, between clock edges.
      cfg_valid  = 1'b1;
      cfg_fcw    = 16'h0800;
      cfg_phase0 = 16'h6000;
      cfg_len    = 16'd0;
      start      = 1'b1;
      step();
      cfg_valid = 1'b0;
      start     = 1'b0;
      sample_en = 1'b1;
      step();
      chk("pre_rst_wrap", wrap, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("arst_theta", theta, 16'h0);
      chk("arst_valid", theta_valid, 1'b0);
      chk("arst_wrap", wrap, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_done", done, 1'b0);
      chk("arst_cfg_ready", cfg_ready, 1'b1);
      #1 rst = 1'b1;
      sample_en = 1'b0;
      // Start with no config after reset uses the cleared registers.
      start = 1'b1;
      step();
      start     = 1'b0;
      sample_en = 1'b1;
      step();
      chk("post_rst_s0_theta", theta, 16'h0);
      chk("post_rst_s0_valid", theta_valid, 1'b1);
      step();
      chk("post_rst_s1_theta", theta, 16'h0);
      abort = 1'b1;
      step();
      abort     = 1'b0;
      sample_en = 1'b0;
      chk("post_rst_abort_busy", busy, 1'b0);

`ifdef CWM_SWEEP_EN
      cfg_valid  = 1'b1;
      cfg_fcw    = 16'h0100;
      cfg_step   = 16'h0100;
      cfg_phase0 = 16'h0000;
      cfg_len    = 16'd4;
      start      = 1'b1;
      step();
      cfg_valid = 1'b0;
      start     = 1'b0;
      sample_en = 1'b1;
      step();
      chk("sweep_s0", theta, 16'h0000);
      step();
      chk("sweep_s1", theta, 16'h0100);
      step();
      chk("sweep_s2", theta, 16'h0300);
      step();
      chk("sweep_s3", theta, 16'h0600);
      step();
      chk("sweep_done", done, 1'b1);
      sample_en = 1'b0;
      cfg_step  = 16'h0000;
      step();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
